// File: rtl/bus_arbiter_pkg.sv
// Shared memory-bus constants and arbiter state encoding.
// AW/DW are also used by the core, ROM, RAM and address decoder.
package bus_arbiter_pkg;
  localparam int AW = 13;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Requester handshake plus memory-bus control signals of the arbiter.
// The tri-state DATA bus stays a plain inout port on the arbiter.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic          REQ0, REQ1;
  logic          WE0, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          ACK0, ACK1;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] ADDRESS;
  logic          MEM_RD, MEM_WR;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    output ACK0, ACK1, RDATA, ADDRESS, MEM_RD, MEM_WR
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    input  ACK0, ACK1, RDATA, ADDRESS, MEM_RD, MEM_WR
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter and fixed-length access sequencer for the
// shared 8-bit memory bus. Port 0 = core, port 1 = DMA/loader.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT = 1
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  bus_arbiter_if.slave  bus,
  inout  wire  [DW-1:0] DATA
);
  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_port, r_last, r_oe;
  logic          r_rd, r_wr, r_ack0, r_ack1;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;

  logic          w_any, w_pick, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // On a tie the port not served last wins; otherwise the lone requester.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

  assign w_any   = bus.REQ0 | bus.REQ1;
  assign w_pick  = rr_pick(bus.REQ0, bus.REQ1, r_last);
  assign w_we    = w_pick ? bus.WE1    : bus.WE0;
  assign w_addr  = w_pick ? bus.ADDR1  : bus.ADDR0;
  assign w_wdata = w_pick ? bus.WDATA1 : bus.WDATA0;

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_port  <= 1'b0;
      r_last  <= 1'b1;
      r_oe    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_port  <= w_pick;
          r_we    <= w_we;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_cnt   <= '0;
          r_rd    <= ~w_we;
          r_wr    <= w_we;
          r_oe    <= w_we;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == CW'(WAIT)) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_oe    <= 1'b0;
            if (!r_we) r_rdata <= DATA;
            r_ack0  <= ~r_port;
            r_ack1  <= r_port;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_last  <= r_port;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ACK0    = r_ack0;
  assign bus.ACK1    = r_ack1;
  assign bus.RDATA   = r_rdata;
  assign bus.ADDRESS = r_addr;
  assign bus.MEM_RD  = r_rd;
  assign bus.MEM_WR  = r_wr;
  assign DATA        = r_oe ? r_wdata : {DW{1'bz}};
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (WAIT=1): reads, writes, round-robin ties,
// dropped requests and reset during a write, against a small memory model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if bus ();
  wire [DW-1:0] data_bus;

  bus_arbiter #(.WAIT(1)) dut (
    .SYS_CLK (clk),
    .SYS_RST (rst),
    .bus     (bus),
    .DATA    (data_bus)
  );

  // Memory model: preloaded in reset, written on strobed edges, drives reads.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rst) begin
      mem[13'h0005] <= 8'hA5;
      mem[13'h0020] <= 8'h11;
      mem[13'h0030] <= 8'h22;
      mem[13'h0040] <= 8'h00;
    end else if (bus.MEM_WR) begin
      mem[bus.ADDRESS] <= data_bus;
    end
  end
  assign data_bus = bus.MEM_RD ? mem[bus.ADDRESS] : {DW{1'bz}};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.REQ0 = 0; bus.REQ1 = 0; bus.WE0 = 0; bus.WE1 = 0;
    bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
  endtask

  always @(negedge clk) begin
    chk("rd_wr_excl", 32'(bus.MEM_RD & bus.MEM_WR), 0);
    chk("ack_excl", 32'(bus.ACK0 & bus.ACK1), 0);
  end

  initial begin
    clear_reqs();
    rst = 1;
    step(2);
    chk("rst_ack0", 32'(bus.ACK0), 0);
    chk("rst_ack1", 32'(bus.ACK1), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    chk("rst_addr", 32'(bus.ADDRESS), 0);
    chk("rst_rd", 32'(bus.MEM_RD), 0);
    chk("rst_wr", 32'(bus.MEM_WR), 0);
    rst = 0;
    step();

    // Single read, port 0
    bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 13'h0005;
    step();
    chk("rd_c1_rd", 32'(bus.MEM_RD), 1);
    chk("rd_c1_addr", 32'(bus.ADDRESS), 32'h5);
    chk("rd_c1_ack", 32'(bus.ACK0), 0);
    step();
    chk("rd_c2_rd", 32'(bus.MEM_RD), 1);
    chk("rd_c2_ack", 32'(bus.ACK0), 0);
    step();
    chk("rd_c3_rd", 32'(bus.MEM_RD), 0);
    chk("rd_c3_ack", 32'(bus.ACK0), 1);
    chk("rd_c3_rdata", 32'(bus.RDATA), 32'hA5);
    chk("rd_c3_addr_hold", 32'(bus.ADDRESS), 32'h5);
    bus.REQ0 = 0;
    step();
    chk("rd_c4_ack", 32'(bus.ACK0), 0);

    // Port 1 write then read-back
    bus.REQ1 = 1; bus.WE1 = 1; bus.ADDR1 = 13'h1010; bus.WDATA1 = 8'h3C;
    step();
    chk("wr_c1_wr", 32'(bus.MEM_WR), 1);
    chk("wr_c1_rd", 32'(bus.MEM_RD), 0);
    chk("wr_c1_data", 32'(data_bus), 32'h3C);
    step();
    chk("wr_c2_wr", 32'(bus.MEM_WR), 1);
    chk("wr_c2_data", 32'(data_bus), 32'h3C);
    step();
    chk("wr_c3_wr", 32'(bus.MEM_WR), 0);
    chk("wr_c3_ack1", 32'(bus.ACK1), 1);
    bus.REQ1 = 0;
    step();
    bus.REQ1 = 1; bus.WE1 = 0;
    step(3);
    chk("rb_ack1", 32'(bus.ACK1), 1);
    chk("rb_rdata", 32'(bus.RDATA), 32'h3C);
    bus.REQ1 = 0;
    step();

    // Simultaneous requests from reset: 0, 1, 0
    rst = 1; step(); rst = 0; step();
    bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 13'h0020;
    bus.REQ1 = 1; bus.WE1 = 0; bus.ADDR1 = 13'h0030;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("tie_c%0d_ack0", c), 32'(bus.ACK0), 32'(c == 3 || c == 11));
      chk($sformatf("tie_c%0d_ack1", c), 32'(bus.ACK1), 32'(c == 7));
      if (c == 3 || c == 11) chk($sformatf("tie_c%0d_rdata", c), 32'(bus.RDATA), 32'h11);
      if (c == 7) chk("tie_c7_rdata", 32'(bus.RDATA), 32'h22);
    end
    bus.REQ0 = 0; bus.REQ1 = 0;
    step();
    chk("tie_idle_rd", 32'(bus.MEM_RD), 0);
    step();

    // Port 0 held, port 1 arrives during port 0 access
    bus.REQ0 = 1; bus.ADDR0 = 13'h0020;
    step();
    bus.REQ1 = 1; bus.ADDR1 = 13'h0030;
    chk("late_c1_addr", 32'(bus.ADDRESS), 32'h20);
    step(2);
    chk("late_c3_ack0", 32'(bus.ACK0), 1);
    step(2);
    chk("late_c5_addr", 32'(bus.ADDRESS), 32'h30);
    step(2);
    chk("late_c7_ack1", 32'(bus.ACK1), 1);
    chk("late_c7_ack0", 32'(bus.ACK0), 0);
    chk("late_c7_rdata", 32'(bus.RDATA), 32'h22);
    bus.REQ1 = 0;
    step(4);
    chk("late_c11_ack0", 32'(bus.ACK0), 1);
    bus.REQ0 = 0;
    step(2);

    // REQ0 dropped in the first access cycle
    bus.REQ0 = 1; bus.ADDR0 = 13'h0005;
    step();
    bus.REQ0 = 0;
    chk("drop_c1_rd", 32'(bus.MEM_RD), 1);
    step(2);
    chk("drop_c3_ack0", 32'(bus.ACK0), 1);
    chk("drop_c3_rdata", 32'(bus.RDATA), 32'hA5);
    step();
    chk("drop_c4_ack0", 32'(bus.ACK0), 0);
    step();
    chk("drop_c5_rd", 32'(bus.MEM_RD), 0);

    // Reset asserted during a port 1 write
    bus.REQ1 = 1; bus.WE1 = 1; bus.ADDR1 = 13'h0040; bus.WDATA1 = 8'h5A;
    step();
    chk("rstw_c1_wr", 32'(bus.MEM_WR), 1);
    #2 rst = 1;
    #1;
    chk("rstw_wr", 32'(bus.MEM_WR), 0);
    chk("rstw_addr", 32'(bus.ADDRESS), 0);
    step(2);
    chk("rstw_ack1", 32'(bus.ACK1), 0);
    rst = 0;
    step();
    chk("rstw_r_wr", 32'(bus.MEM_WR), 1);
    chk("rstw_r_addr", 32'(bus.ADDRESS), 32'h40);
    chk("rstw_r_data", 32'(data_bus), 32'h5A);
    step(2);
    chk("rstw_r_ack1", 32'(bus.ACK1), 1);
    bus.REQ1 = 0;
    step();
    chk("rstw_mem", 32'(mem[13'h0040]), 32'h5A);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter and access sequencer for the shared 8-bit memory bus (13-bit ADDRESS, tri-state DATA, MEM_RD/MEM_WR) that feeds the address decoder, ROM and RAM. It sits between the memory bus and two requesters: port 0 is the core, port 1 is a DMA/loader engine. It accepts one request at a time, drives the bus for a fixed number of cycles, and returns read data with a one-cycle acknowledge. Round-robin arbitration prevents either port from starving the other.

## Interface
- AW, 13, address width
- DW, 8, data width
- WAIT, 1, extra access cycles beyond the first; the access phase lasts WAIT+1 cycles, WAIT ≥ 0
- SYS_CLK  in  1  single system clock; all state changes on the rising edge
- SYS_RST  in  1  asynchronous, active-high reset
- REQ0 / REQ1  in  1  access request, held high until the matching ACK
- WE0 / WE1  in  1  1 = write, 0 = read; stable while REQ is high
- ADDR0 / ADDR1  in  AW  request address; stable while REQ is high
- WDATA0 / WDATA1  in  DW  write data; stable while REQ is high
- ACK0 / ACK1  out  1  one-cycle completion pulse; reset 0
- RDATA  out  DW  read data, shared by both ports, valid in the ACK cycle and held until the next read completes; reset 0
- ADDRESS  out  AW  bus address; reset 0
- MEM_RD  out  1  bus read strobe; reset 0
- MEM_WR  out  1  bus write strobe; reset 0
- DATA  inout  DW  shared data bus; driven only during write ACCESS cycles, otherwise high-Z; high-Z in reset

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one REQ is high, grant that port.
  - If both are high, grant the port that was not served last. The last-served register resets to 1, so port 0 wins the first tie.
  - On grant: latch ADDR, WE, WDATA and the port id, clear the wait counter, and move to ACCESS.
- **ACCESS** (WAIT+1 cycles)
  - ADDRESS = latched address.
  - Read: MEM_RD = 1.
  - Write: MEM_WR = 1 and DATA = latched WDATA.
  - The wait counter increments each cycle. When the counter equals WAIT:
    - on a read, capture DATA into RDATA on that edge;
    - go to DONE.
- **DONE** (1 cycle)
  - MEM_RD, MEM_WR = 0; DATA high-Z; ADDRESS holds its value.
  - ACK of the granted port = 1.
  - Update last-served to the granted port.
  - Go to IDLE.
- Inputs are sampled only in IDLE. REQ/ADDR changes during ACCESS or DONE are ignored.
- A requester that drops REQ mid-transaction does not abort it. The access completes and ACK still pulses.
- A requester that keeps REQ high after its ACK is treated as issuing a new request. It competes in the next IDLE cycle.
- The counter is wide enough for WAIT: $clog2(WAIT+1), minimum 1 bit. It saturates at WAIT and never wraps.
- SYS_RST asserted at any time, including mid-ACCESS:
  - immediately returns the FSM to IDLE;
  - clears all outputs to their reset values;
  - tri-states DATA.
  - The interrupted write has no defined memory effect, and no ACK is issued.
- MEM_RD and MEM_WR are never high simultaneously. ACK0 and ACK1 are never high simultaneously.

## Timing
- Request high at edge N while in IDLE: bus strobes are active in cycles N+1 … N+1+WAIT, and ACK is high in cycle N+WAIT+2.
- Latency from request to ACK is WAIT+2 cycles.
- Minimum spacing between transactions is WAIT+3 cycles: IDLE, ACCESS×(WAIT+1), DONE.
- All outputs are registered. DATA is driven from a registered output enable.

## Structure
- The shared package holds:
  - the state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - bus width constants AW = 13 and DW = 8, also used by the core, ROM, RAM and address decoder.
- A single module with no sub-module is required.
- The round-robin pick is a small combinational function inside the module.
- The system top instantiates bus_arbiter between the core/DMA and the shared bus nets.

## Test plan
- **Single read:** WAIT=1, port 0 reads 13'h0005 and ROM returns 8'hA5.
  - MEM_RD is high for 2 cycles.
  - ACK0 pulses in cycle N+3.
  - RDATA = 8'hA5.
- **Single write then read-back:** port 1 writes 8'h3C to a RAM address, then reads the same address.
  - MEM_WR is high for 2 cycles with DATA = 8'h3C.
  - The read returns 8'h3C on ACK1.
- **Simultaneous requests from reset:** REQ0 and REQ1 rise together and are held.
  - Port 0 is served first, then port 1, then port 0.
  - ACKs alternate 0, 1, 0, each spaced 4 cycles apart.
- **Continuous REQ0 with a late REQ1:** REQ0 is held high, and REQ1 rises during port 0's ACCESS.
  - The next grant goes to port 1.
  - Port 0 is never granted twice in a row while REQ1 is pending.
- **REQ dropped mid-access:** REQ0 falls in the first ACCESS cycle.
  - The access completes and ACK0 still pulses.
  - FSM returns to IDLE.
- **Reset mid-write:** SYS_RST is asserted during ACCESS of a write.
  - MEM_WR = 0, DATA = Z and ADDRESS = 0 immediately.
  - No ACK is issued.
  - After release, a pending REQ1 is served normally.
